// File: rtl/result_matrix_writer.sv
// result_matrix_writer
// Accumulates each group of DOT_LENGTH products into one element C[i][j].
// Each product beat carries LANES products. Every completed element is
// written to the C memory in row-major order, one address per element.
// row_done pulses after the last element of each row is written, and done
// stays high once the whole matrix has been written.
module result_matrix_writer #(
    parameter int MATRIX_C_ROWS      = 8,
    parameter int MATRIX_C_COLUMNS   = 8,
    parameter int MATRIX_C_MEM_DEPTH = 64,
    parameter int DOT_LENGTH         = 8,
    parameter int LANES              = 4,
    parameter int MATRIX_MEM_WIDTH   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  prod_valid,
    output logic                                  prod_ready,
    input  logic [LANES*MATRIX_MEM_WIDTH-1:0]     prod_data,
    output logic                                  wr_en,
    input  logic                                  wr_ready,
    output logic [$clog2(MATRIX_C_MEM_DEPTH)-1:0] wr_address,
    output logic [MATRIX_MEM_WIDTH-1:0]           wr_data,
    output logic                                  row_done,
    output logic                                  done,
    output logic                                  busy
);

    localparam int W     = MATRIX_MEM_WIDTH;
    localparam int BEATS = DOT_LENGTH / LANES;
    localparam int N     = MATRIX_C_ROWS * MATRIX_C_COLUMNS;
    localparam int AW    = $clog2(MATRIX_C_MEM_DEPTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (MATRIX_C_COLUMNS > 1) ? $clog2(MATRIX_C_COLUMNS) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(MATRIX_C_COLUMNS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    acc;
    logic [W-1:0]    result;
    logic [W-1:0]    lane_sum;
    logic [W-1:0]    sum_next;
    logic [BW-1:0]   beat;
    logic [AW-1:0]   address;
    logic [CW-1:0]   col;
    logic            row_done_q;
    logic            accept;
    logic            write_fire;

    // Sum the lanes of the current beat and fold it into the running element sum.
    always_comb begin
        // NOTE: lane_sum is given a value before the loop, so no latch is inferred,
        // and it uses blocking '=' so each lane adds to the running value.
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + prod_data[k*W +: W];
        end
        sum_next = (beat == '0) ? lane_sum : acc + lane_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking '<=' so every flop samples
        // pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Compute the next state and the handshake/status outputs.
    always_comb begin
        state_next = state;
        prod_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
                if (prod_valid && beat == LAST_BEAT) state_next = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (wr_ready) state_next = (address == LAST_ADDR) ? DONE : ACCUM;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = ACCUM;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept     = prod_valid && prod_ready;
    assign write_fire = wr_en && wr_ready;

    // Update the accumulator, beat/address/column counters and the row_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            result     <= '0;
            beat       <= '0;
            address    <= '0;
            col        <= '0;
            row_done_q <= 1'b0;
        end else begin
            row_done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        beat    <= '0;
                        address <= '0;
                        col     <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_next;
                        if (beat == LAST_BEAT) begin
                            result <= sum_next;
                            beat   <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (write_fire) begin
                        row_done_q <= (col == LAST_COL);
                        col        <= (col == LAST_COL) ? '0 : col + CW'(1);
                        // The address stays at the last element in DONE; a restart
                        // clears it, so the counter never wraps on its own.
                        if (address != LAST_ADDR) address <= address + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_address = address;
    assign wr_data    = result;
    assign row_done   = row_done_q;

endmodule
